mips_instr_encoder: RTL

//  Encoding counterpart of the control decoder. Takes symbolic instructions (op id plus fields),

---
 rtl/mips_isa_pkg.sv | 87 ++++++++
 rtl/mips_instr_pack.sv | 56 +++++
 rtl/mips_instr_encoder.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/mips_isa_pkg.sv
`default_nettype none
// ============================================================================
// mips_isa_pkg : MIPS op ids, opcode/funct values and encoder FSM states
// Rev 1.0
// ============================================================================
package mips_isa_pkg;

    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_ADDU  = 5'd1;
    localparam logic [4:0] OP_SUB   = 5'd2;
    localparam logic [4:0] OP_SUBU  = 5'd3;
    localparam logic [4:0] OP_AND   = 5'd4;
    localparam logic [4:0] OP_OR    = 5'd5;
    localparam logic [4:0] OP_XOR   = 5'd6;
    localparam logic [4:0] OP_NOR   = 5'd7;
    localparam logic [4:0] OP_SLT   = 5'd8;
    localparam logic [4:0] OP_SLTU  = 5'd9;
    localparam logic [4:0] OP_SLL   = 5'd10;
    localparam logic [4:0] OP_SRL   = 5'd11;
    localparam logic [4:0] OP_SRA   = 5'd12;
    localparam logic [4:0] OP_JR    = 5'd13;
    localparam logic [4:0] OP_JALR  = 5'd14;
    localparam logic [4:0] OP_LW    = 5'd15;
    localparam logic [4:0] OP_SW    = 5'd16;
    localparam logic [4:0] OP_LUI   = 5'd17;
    localparam logic [4:0] OP_ADDI  = 5'd18;
    localparam logic [4:0] OP_ADDIU = 5'd19;
    localparam logic [4:0] OP_ANDI  = 5'd20;
    localparam logic [4:0] OP_SLTI  = 5'd21;
    localparam logic [4:0] OP_SLTIU = 5'd22;
    localparam logic [4:0] OP_BEQ   = 5'd23;
    localparam logic [4:0] OP_J     = 5'd24;
    localparam logic [4:0] OP_JAL   = 5'd25;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_JAL   = 6'h03;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_ADDIU = 6'h09;
    localparam logic [5:0] OPC_SLTI  = 6'h0a;
    localparam logic [5:0] OPC_SLTIU = 6'h0b;
    localparam logic [5:0] OPC_ANDI  = 6'h0c;
    localparam logic [5:0] OPC_LUI   = 6'h0f;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2a;
    localparam logic [5:0] FN_SLTU = 6'h2b;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } enc_state_e;

    function automatic logic [31:0] fmt_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] shamt,
                                          input logic [5:0] funct);
        return {OPC_RTYPE, rs, rt, rd, shamt, funct};
    endfunction

    function automatic logic [31:0] fmt_i(input logic [5:0] opc, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {opc, rs, rt, imm};
    endfunction

    function automatic logic [31:0] fmt_j(input logic [5:0] opc, input logic [25:0] target);
        return {opc, target};
    endfunction

endpackage
`default_nettype wire

// File: rtl/mips_instr_pack.sv
`default_nettype none
// ============================================================================
// mips_instr_pack : combinational {op id, fields} -> {32-bit MIPS word, illegal}
// Rev 1.0
// ============================================================================
module mips_instr_pack
    import mips_isa_pkg::*;
(
    input  logic [4:0]  op_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  shamt_i,
    input  logic [15:0] imm_i,
    input  logic [25:0] target_i,
    output logic [31:0] word_o,
    output logic        illegal_o
);

    // Fields that the ISA defines as unused are forced to zero here.
    always_comb begin
        word_o    = 32'h0;
        illegal_o = 1'b0;
        case (op_i)
            OP_ADD:   word_o = fmt_r(rs_i, rt_i, rd_i, 5'd0, FN_ADD);
            OP_ADDU:  word_o = fmt_r(rs_i, rt_i, rd_i, 5'd0, FN_ADDU);
            OP_SUB:   word_o = fmt_r(rs_i, rt_i, rd_i, 5'd0, FN_SUB);
            OP_SUBU:  word_o = fmt_r(rs_i, rt_i, rd_i, 5'd0, FN_SUBU);
            OP_AND:   word_o = fmt_r(rs_i, rt_i, rd_i, 5'd0, FN_AND);
            OP_OR:    word_o = fmt_r(rs_i, rt_i, rd_i, 5'd0, FN_OR);
            OP_XOR:   word_o = fmt_r(rs_i, rt_i, rd_i, 5'd0, FN_XOR);
            OP_NOR:   word_o = fmt_r(rs_i, rt_i, rd_i, 5'd0, FN_NOR);
            OP_SLT:   word_o = fmt_r(rs_i, rt_i, rd_i, 5'd0, FN_SLT);
            OP_SLTU:  word_o = fmt_r(rs_i, rt_i, rd_i, 5'd0, FN_SLTU);
            OP_SLL:   word_o = fmt_r(5'd0, rt_i, rd_i, shamt_i, FN_SLL);
            OP_SRL:   word_o = fmt_r(5'd0, rt_i, rd_i, shamt_i, FN_SRL);
            OP_SRA:   word_o = fmt_r(5'd0, rt_i, rd_i, shamt_i, FN_SRA);
            OP_JR:    word_o = fmt_r(rs_i, 5'd0, 5'd0, 5'd0, FN_JR);
            OP_JALR:  word_o = fmt_r(rs_i, 5'd0, rd_i, 5'd0, FN_JALR);
            OP_LW:    word_o = fmt_i(OPC_LW, rs_i, rt_i, imm_i);
            OP_SW:    word_o = fmt_i(OPC_SW, rs_i, rt_i, imm_i);
            OP_LUI:   word_o = fmt_i(OPC_LUI, 5'd0, rt_i, imm_i);
            OP_ADDI:  word_o = fmt_i(OPC_ADDI, rs_i, rt_i, imm_i);
            OP_ADDIU: word_o = fmt_i(OPC_ADDIU, rs_i, rt_i, imm_i);
            OP_ANDI:  word_o = fmt_i(OPC_ANDI, rs_i, rt_i, imm_i);
            OP_SLTI:  word_o = fmt_i(OPC_SLTI, rs_i, rt_i, imm_i);
            OP_SLTIU: word_o = fmt_i(OPC_SLTIU, rs_i, rt_i, imm_i);
            OP_BEQ:   word_o = fmt_i(OPC_BEQ, rs_i, rt_i, imm_i);
            OP_J:     word_o = fmt_j(OPC_J, target_i);
            OP_JAL:   word_o = fmt_j(OPC_JAL, target_i);
            default:  illegal_o = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mips_instr_encoder.sv
`default_nettype none
// ============================================================================
// mips_instr_encoder : packs symbolic instructions and streams them into IMEM
// Rev 1.0
// ============================================================================
module mips_instr_encoder
    import mips_isa_pkg::*;
#(
    parameter int          ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    input  logic              in_last,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    input  logic              wr_ready,
    output logic              busy,
    output logic              done,
    output logic              err_illegal,
    output logic              err_ovf,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [ADDR_W-1:0] C_BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] C_LAST = '1;

    enc_state_e        state_q, state_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              ill_q, ill_d;
    logic              ovf_q, ovf_d;

    logic [31:0]       w_word;
    logic              w_illegal;
    logic              w_hs;
    logic              w_accept;
    logic              w_at_end;

    mips_instr_pack u_pack (
        .op_i      (in_op),
        .rs_i      (in_rs),
        .rt_i      (in_rt),
        .rd_i      (in_rd),
        .shamt_i   (in_shamt),
        .imm_i     (in_imm),
        .target_i  (in_target),
        .word_o    (w_word),
        .illegal_o (w_illegal)
    );

    assign in_ready = (state_q == ST_RUN) && (!wr_en_q || wr_ready);
    assign w_hs     = wr_en_q && wr_ready;
    assign w_accept = in_valid && in_ready;
    assign w_at_end = w_hs && (addr_q == C_LAST);

    always_comb begin
        state_d = state_q;
        wr_en_d = wr_en_q && !wr_ready;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        ill_d   = ill_q;
        ovf_d   = ovf_q;

        if (w_hs) begin
            cnt_d = cnt_q + 1'b1;
            if (addr_q == C_LAST) begin
                ovf_d = 1'b1;
            end else begin
                addr_d = addr_q + 1'b1;
            end
        end

        if (w_accept) begin
            if (w_illegal) begin
                ill_d = 1'b1;
            end else begin
                wr_en_d = 1'b1;
                data_d  = w_word;
            end
        end

        // Address space is exhausted: a word accepted alongside the final write has nowhere to go.
        if (w_at_end) begin
            wr_en_d = 1'b0;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                    addr_d  = C_BASE;
                    cnt_d   = '0;
                    ill_d   = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            ST_RUN: begin
                if (w_at_end || (w_accept && in_last)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!wr_en_q || w_hs) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            wr_en_q <= 1'b0;
            addr_q  <= C_BASE;
            data_q  <= 32'h0;
            cnt_q   <= '0;
            ill_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_en_q <= wr_en_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            ill_q   <= ill_d;
            ovf_q   <= ovf_d;
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_addr     = addr_q;
    assign wr_data     = data_q;
    assign busy        = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done        = (state_q == ST_DONE);
    assign err_illegal = ill_q;
    assign err_ovf     = ovf_q;
    assign word_count  = cnt_q;

endmodule
`default_nettype wire
